regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among N writeback requesters (ALU, load unit, CSR/mul).
- Round-robin arbitration with a valid/ready handshake; the granted write is presented on a registered write port.
- Holds a per-register busy scoreboard (claim at issue, clear at commit) so issue logic can detect RAW/WAW hazards on the two read operands.

Parameters:
- REQUESTERS, 3, number of writeback sources (2..8).
- RESET_PRIO, 0, requester index with highest priority after reset.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- req_valid  in  REQUESTERS  per-requester write request.
- req_addr  in  5*REQUESTERS  destination register, slice i = [5i+4:5i].
- req_data  in  32*REQUESTERS  write data, slice i = [32i+31:32i].
- req_ready  out  REQUESTERS  one-hot grant; combinational.
- wr_en  out  1  register file write enable; registered.
- wr_addr  out  5  register file write address; registered.
- wr_data  out  32  register file write data; registered.
- claim_valid  in  1  issue stage reserves a destination.
- claim_addr  in  5  register being reserved.
- claim_ready  out  1  reservation accepted this cycle; combinational.
- query_a_addr, query_b_addr  in  5 each  operand registers to check.
- query_a_busy, query_b_busy  out  1 each  operand has a pending write; combinational.

Behaviour:
- Reset (rst=0 at posedge): wr_en=0, wr_addr=0, wr_data=0, busy[31:0]=0, round-robin pointer set so RESET_PRIO wins first. Reset mid-operation drops any staged write and clears all busy bits. req_ready=0 and claim_ready=0 while rst=0.
- Arbitration:
  - The search starts at (last_grant+1) mod REQUESTERS; the first valid requester gets req_ready=1.
  - At most one req_ready is high per cycle. A transfer occurs when req_valid & req_ready are both high.
  - last_grant updates only on a transfer.
  - A requester keeps valid, addr and data stable until ready (requirement on sources). The arbiter grants every cycle; there is no backpressure from the register file.
- Write port:
  - A transfer in cycle t gives wr_en=1, wr_addr and wr_data equal to the granted slice in cycle t+1 (1-cycle latency).
  - The register file commits at the end of cycle t+1. With no transfer, wr_en=0 next cycle and wr_addr/wr_data hold their values.
- x0 handling: requests to address 0 are granted and consumed, but wr_en stays 0. busy[0] is never set; query on address 0 returns busy=0.
- Scoreboard:
  - busy[r] is set at posedge when claim_valid & claim_ready & claim_addr=r≠0.
  - busy[r] is cleared at posedge when wr_en=1 and wr_addr=r.
  - claim_ready = !busy[claim_addr] | (wr_en & wr_addr==claim_addr). Only one outstanding write per register.
  - Simultaneous clear and claim of the same register: the claim wins, and busy stays 1.
- query_x_busy = busy[query_x_addr]. This includes the cycle where that write is on the port (wr_en=1), unless forwarding is enabled.
- Writes to a register that is not busy are legal (untracked writes) and leave busy unchanged.
- Back-to-back grants to one requester are allowed only when no other requester is valid.

Optional Feature:
- Macro REGFILE_WB_FWD_EN.
- Defined:
  - Adds outputs fwd_a_hit, fwd_b_hit (1 bit) and fwd_a_data, fwd_b_data (32 bit).
  - fwd_x_hit = wr_en & wr_addr==query_x_addr & query_x_addr≠0; fwd_x_data = wr_data.
  - query_x_busy is masked to 0 when fwd_x_hit=1, so issue proceeds one cycle earlier.
- Undefined: these ports are absent, and busy is reported through the commit cycle as above.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0, query busy=0. Release -> requester 0 granted first.
- Round-robin: all 3 requesters valid continuously, addr 5/6/7, data 0xA/0xB/0xC -> grants 0,1,2,0 on successive cycles. wr_addr sequence 5,6,7,5, each one cycle after its grant, with matching data.
- Scoreboard: claim r9 -> query_a_addr=9 busy=1. Requester 1 writes r9=0xDEADBEEF -> wr_en in the next cycle, busy clears after that edge. A second claim of r9 while busy -> claim_ready=0.
- Same-cycle clear and claim: wr_en=1, wr_addr=12 while claim_valid=1, claim_addr=12 -> claim_ready=1, busy[12] remains 1.
- x0: claim r0 -> claim_ready=1, busy[0]=0. Request write r0=0x1234 -> req_ready=1, wr_en stays 0.
- Mid-operation reset: transfer to r3 granted, rst=0 on the next edge -> wr_en=0 and all busy=0 after that edge. With REGFILE_WB_FWD_EN, a write of r4=0x55 on the port with query_b_addr=4 -> fwd_b_hit=1, fwd_b_data=0x55, query_b_busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, plus a per-register busy scoreboard.
// Optional macro REGFILE_WB_FWD_EN adds same-cycle forwarding of the write port to the two operand queries.
module regfile_wb_arbiter #(
    parameter int REQUESTERS = 3,
    parameter int RESET_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQUESTERS-1:0]     req_valid,
    input  logic [5*REQUESTERS-1:0]   req_addr,
    input  logic [32*REQUESTERS-1:0]  req_data,
    output logic [REQUESTERS-1:0]     req_ready,
    output logic                      wr_en,
    output logic [4:0]                wr_addr,
    output logic [31:0]               wr_data,
    input  logic                      claim_valid,
    input  logic [4:0]                claim_addr,
    output logic                      claim_ready,
    input  logic [4:0]                query_a_addr,
    input  logic [4:0]                query_b_addr,
`ifdef REGFILE_WB_FWD_EN
    output logic                      fwd_a_hit,
    output logic                      fwd_b_hit,
    output logic [31:0]               fwd_a_data,
    output logic [31:0]               fwd_b_data,
`endif
    output logic                      query_a_busy,
    output logic                      query_b_busy
);

    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    // Pointer value that makes RESET_PRIO the first index searched.
    localparam logic [PW-1:0] PTR_RESET = PW'((RESET_PRIO + REQUESTERS - 1) % REQUESTERS);

    logic [PW-1:0]           last_grant_r;
    logic [REQUESTERS-1:0]   grant_s;
    logic [PW-1:0]           grant_idx_s;
    logic                    grant_any_s;
    logic [PW:0]             idx_s;
    logic [4:0]              sel_addr_s;
    logic [31:0]             sel_data_s;

    logic                    wr_en_r;
    logic [4:0]              wr_addr_r;
    logic [31:0]             wr_data_r;

    logic [31:0]             busy_r;
    logic [31:0]             busy_next_s;
    logic                    claim_ready_s;
    logic                    claim_fire_s;
    logic                    busy_a_s;
    logic                    busy_b_s;
    logic                    hit_a_s;
    logic                    hit_b_s;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        idx_s       = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            idx_s = {1'b0, last_grant_r} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(REQUESTERS)) begin
                idx_s = idx_s - (PW+1)'(REQUESTERS);
            end else begin
                idx_s = idx_s;
            end
            if (rst && !grant_any_s && req_valid[idx_s[PW-1:0]]) begin
                grant_any_s                 = 1'b1;
                grant_idx_s                 = idx_s[PW-1:0];
                grant_s[idx_s[PW-1:0]]      = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot select of the granted requester's address and data.
    always_comb begin
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        for (int i = 0; i < REQUESTERS; i++) begin
            sel_addr_s = sel_addr_s | (req_addr[5*i +: 5]   & {5{grant_s[i]}});
            sel_data_s = sel_data_s | (req_data[32*i +: 32] & {32{grant_s[i]}});
        end
    end

    assign req_ready = grant_s;

    // Round-robin pointer advances only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_r <= PTR_RESET;
        end else if (grant_any_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 5'd0;
            wr_data_r <= 32'd0;
        end else if (grant_any_s) begin
            wr_en_r   <= (sel_addr_s != 5'd0);
            wr_addr_r <= sel_addr_s;
            wr_data_r <= sel_data_s;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

    // A register being committed this cycle can be re-claimed in the same cycle.
    assign claim_ready_s = rst & (~busy_r[claim_addr] | (wr_en_r & (wr_addr_r == claim_addr)));
    assign claim_fire_s  = claim_valid & claim_ready_s & (claim_addr != 5'd0);
    assign claim_ready   = claim_ready_s;

    // Next busy vector: commit clears, claim sets afterwards so it wins a collision.
    always_comb begin
        busy_next_s = busy_r;
        if (wr_en_r) begin
            busy_next_s[wr_addr_r] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (claim_fire_s) begin
            busy_next_s[claim_addr] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Busy scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy_a_s = busy_r[query_a_addr];
    assign busy_b_s = busy_r[query_b_addr];

`ifdef REGFILE_WB_FWD_EN
    assign hit_a_s      = wr_en_r & (wr_addr_r == query_a_addr) & (query_a_addr != 5'd0);
    assign hit_b_s      = wr_en_r & (wr_addr_r == query_b_addr) & (query_b_addr != 5'd0);
    assign fwd_a_hit    = hit_a_s;
    assign fwd_b_hit    = hit_b_s;
    assign fwd_a_data   = wr_data_r;
    assign fwd_b_data   = wr_data_r;
`else
    assign hit_a_s      = 1'b0;
    assign hit_b_s      = 1'b0;
`endif

    assign query_a_busy = busy_a_s & ~hit_a_s;
    assign query_b_busy = busy_b_s & ~hit_b_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a behavioural arbiter/scoreboard model.
module tb_regfile_wb_arbiter;

    localparam int R  = 3;
    localparam int RP = 0;

    logic              clk = 1'b0;
    logic              rst;
    logic [R-1:0]      req_valid;
    logic [4:0]        ra [R];
    logic [31:0]       rd [R];
    logic [5*R-1:0]    req_addr;
    logic [32*R-1:0]   req_data;
    logic [R-1:0]      req_ready;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              claim_valid;
    logic [4:0]        claim_addr;
    logic              claim_ready;
    logic [4:0]        query_a_addr, query_b_addr;
    logic              query_a_busy, query_b_busy;
`ifdef REGFILE_WB_FWD_EN
    logic              fwd_a_hit, fwd_b_hit;
    logic [31:0]       fwd_a_data, fwd_b_data;
`endif

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < R; i++) begin
            req_addr[5*i +: 5]   = ra[i];
            req_data[32*i +: 32] = rd[i];
        end
    end

    regfile_wb_arbiter #(.REQUESTERS(R), .RESET_PRIO(RP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .query_a_addr(query_a_addr), .query_b_addr(query_b_addr),
`ifdef REGFILE_WB_FWD_EN
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
`endif
        .query_a_busy(query_a_busy), .query_b_busy(query_b_busy)
    );

    // Reference model state
    int          m_last;
    bit [31:0]   m_busy;
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = (RP + R - 1) % R;
        m_busy = '0;
        m_en   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    function automatic int model_grant();
        if (!rst) return -1;
        for (int k = 1; k <= R; k++) begin
            if (req_valid[(m_last + k) % R]) return (m_last + k) % R;
        end
        return -1;
    endfunction

    // One clock cycle: check combinational outputs, then advance the model across the edge.
    task automatic step(output int g);
        logic [R-1:0] exp_rdy;
        bit exp_claim, fa, fb;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_claim = rst && (!m_busy[claim_addr] || (m_en && m_addr == claim_addr));
        fa = 1'b0;
        fb = 1'b0;
`ifdef REGFILE_WB_FWD_EN
        fa = m_en && m_addr == query_a_addr && query_a_addr != 5'd0;
        fb = m_en && m_addr == query_b_addr && query_b_addr != 5'd0;
        chk("fwd_a_hit", fwd_a_hit, fa);
        chk("fwd_b_hit", fwd_b_hit, fb);
        chk("fwd_a_data", fwd_a_data, m_data);
        chk("fwd_b_data", fwd_b_data, m_data);
`endif
        chk("req_ready", req_ready, exp_rdy);
        chk("wr_en", wr_en, m_en);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("claim_ready", claim_ready, exp_claim);
        chk("query_a_busy", query_a_busy, m_busy[query_a_addr] && !fa);
        chk("query_b_busy", query_b_busy, m_busy[query_b_addr] && !fb);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_en) m_busy[m_addr] = 1'b0;
            if (claim_valid && exp_claim && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
            if (g >= 0) begin
                m_last = g;
                m_en   = (ra[g] != 5'd0);
                m_addr = ra[g];
                m_data = rd[g];
                if (ra[g] != 5'd0) exp_q.push_back('{a: ra[g], d: rd[g]});
            end else begin
                m_en = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every enabled write must match the oldest expected transfer.
    always @(posedge clk) begin
        #2;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mon_wr_addr", wr_addr, e.a);
                chk("mon_wr_data", wr_data, e.d);
            end
        end
    end

    int g;
    bit [R-1:0] pending;

    initial begin
        rst = 1'b0; req_valid = '0; claim_valid = 1'b0; claim_addr = 5'd0;
        query_a_addr = 5'd0; query_b_addr = 5'd0; pending = '0;
        for (int i = 0; i < R; i++) begin ra[i] = 5'd0; rd[i] = 32'd0; end
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // Reset held with every requester valid
        for (int i = 0; i < R; i++) begin ra[i] = 5'(5 + i); rd[i] = 32'hA + 32'(i); end
        req_valid = '1; query_a_addr = 5'd5; query_b_addr = 5'd6;
        repeat (2) step(g);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", req_ready, 3'b001 << (k % 3));
            step(g);
        end
        req_valid = '0;
        step(g);

        // Claim r9, reject a second claim, then commit it
        claim_valid = 1'b1; claim_addr = 5'd9; query_a_addr = 5'd9;
        step(g);
        #1 chk("busy9_set", query_a_busy, 1'b1);
        chk("claim9_rejected", claim_ready, 1'b0);
        step(g);
        claim_valid = 1'b0; ra[1] = 5'd9; rd[1] = 32'hDEADBEEF; req_valid = 3'b010;
        step(g);
        req_valid = '0;
        #1 chk("wr9_en", wr_en, 1'b1);
        chk("wr9_data", wr_data, 32'hDEADBEEF);
`ifndef REGFILE_WB_FWD_EN
        chk("busy9_commit_cycle", query_a_busy, 1'b1);
`endif
        step(g);
        #1 chk("busy9_clr", query_a_busy, 1'b0);

        // Same-cycle clear and re-claim of r12
        claim_valid = 1'b1; claim_addr = 5'd12; query_a_addr = 5'd12;
        step(g);
        claim_valid = 1'b0; ra[2] = 5'd12; rd[2] = 32'h1200_00C0; req_valid = 3'b100;
        step(g);
        req_valid = '0; claim_valid = 1'b1; claim_addr = 5'd12;
        #1 chk("claim12_bypass", claim_ready, 1'b1);
        step(g);
        claim_valid = 1'b0;
        #1 chk("busy12_kept", query_a_busy, 1'b1);

        // x0: claim and write are accepted but have no effect
        claim_valid = 1'b1; claim_addr = 5'd0; query_a_addr = 5'd0;
        #1 chk("claim0_ready", claim_ready, 1'b1);
        step(g);
        claim_valid = 1'b0;
        #1 chk("busy0", query_a_busy, 1'b0);
        ra[0] = 5'd0; rd[0] = 32'h1234; req_valid = 3'b001;
        #1 chk("x0_ready", req_ready, 3'b001);
        step(g);
        req_valid = '0;
        #1 chk("x0_no_wr_en", wr_en, 1'b0);
        step(g);

        // Reset while a write to r3 is on the port
        claim_valid = 1'b1; claim_addr = 5'd3; query_a_addr = 5'd3; query_b_addr = 5'd12;
        step(g);
        claim_valid = 1'b0; ra[0] = 5'd3; rd[0] = 32'h33; req_valid = 3'b001;
        step(g);
        req_valid = '0; rst = 1'b0;
        step(g);
        rst = 1'b1;
        #1 chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy3", query_a_busy, 1'b0);
        chk("rst_busy12", query_b_busy, 1'b0);

`ifdef REGFILE_WB_FWD_EN
        claim_valid = 1'b1; claim_addr = 5'd4;
        step(g);
        claim_valid = 1'b0; ra[1] = 5'd4; rd[1] = 32'h55; req_valid = 3'b010;
        step(g);
        req_valid = '0; query_b_addr = 5'd4;
        #1 chk("fwd_b_hit4", fwd_b_hit, 1'b1);
        chk("fwd_b_data4", fwd_b_data, 32'h55);
        chk("fwd_b_busy4", query_b_busy, 1'b0);
        step(g);
`endif

        // Randomized traffic with sources holding requests until granted
        pending = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!pending[i] && $urandom_range(0, 99) < 40) begin
                    pending[i] = 1'b1;
                    ra[i] = 5'($urandom_range(0, 15));
                    rd[i] = $urandom;
                end
            end
            req_valid    = pending;
            claim_valid  = ($urandom_range(0, 1) == 1);
            claim_addr   = 5'($urandom_range(0, 15));
            query_a_addr = 5'($urandom_range(0, 15));
            query_b_addr = 5'($urandom_range(0, 15));
            rst          = ($urandom_range(0, 199) != 0);
            step(g);
            if (g >= 0) pending[g] = 1'b0;
        end
        rst = 1'b1; req_valid = '0; claim_valid = 1'b0;
        repeat (2) step(g);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
